// File: rtl/divide_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): restoring division, one quotient bit per cycle,
// valid/ready handshakes on both the operand and the result side.
module divide_unit (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_data_a,
    input  logic [31:0] i_data_b,
    input  logic [1:0]  i_divop,
    input  logic        i_flush,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_data
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e      state_q;
    logic [1:0]  op_q;
    logic [31:0] dvd_q;       // dividend magnitude, refilled with quotient bits from the LSB
    logic [31:0] dvs_q;
    logic [32:0] rem_q;
    logic [4:0]  cnt_q;
    logic        neg_quo_q;
    logic        neg_rem_q;

    logic        is_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic        div_zero;
    logic        overflow;
    logic [31:0] special_data;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        qbit;
    logic [32:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] result;

    always_comb begin
        is_signed = ~i_divop[0];
        abs_a     = (is_signed && i_data_a[31]) ? -i_data_a : i_data_a;
        abs_b     = (is_signed && i_data_b[31]) ? -i_data_b : i_data_b;
        div_zero  = (i_data_b == 32'h0000_0000);
        overflow  = is_signed && (i_data_a == 32'h8000_0000) && (i_data_b == 32'hFFFF_FFFF);
        if (div_zero) begin
            // Remainder of a divide-by-zero is the raw dividend, without sign fix-up
            special_data = i_divop[1] ? i_data_a : 32'hFFFF_FFFF;
        end else begin
            special_data = i_divop[1] ? 32'h0000_0000 : 32'h8000_0000;
        end

        shifted  = {rem_q[31:0], dvd_q[31]};
        diff     = shifted - {1'b0, dvs_q};
        qbit     = ~diff[32];
        rem_next = qbit ? diff : shifted;
        quo_next = {dvd_q[30:0], qbit};
        quo_fix  = neg_quo_q ? -quo_next : quo_next;
        rem_fix  = neg_rem_q ? -rem_next[31:0] : rem_next[31:0];
        result   = op_q[1] ? rem_fix : quo_fix;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            op_q      <= 2'b00;
            dvd_q     <= 32'h0000_0000;
            dvs_q     <= 32'h0000_0000;
            rem_q     <= 33'h0_0000_0000;
            cnt_q     <= 5'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            o_ready   <= 1'b1;
            o_valid   <= 1'b0;
            o_data    <= 32'h0000_0000;
        end else if (i_flush) begin
            state_q <= StIdle;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (i_valid) begin
                        op_q      <= i_divop;
                        dvd_q     <= abs_a;
                        dvs_q     <= abs_b;
                        rem_q     <= 33'h0_0000_0000;
                        cnt_q     <= 5'd0;
                        neg_quo_q <= is_signed & (i_data_a[31] ^ i_data_b[31]);
                        neg_rem_q <= is_signed & i_data_a[31];
                        o_ready   <= 1'b0;
                        if (div_zero || overflow) begin
                            state_q <= StDone;
                            o_valid <= 1'b1;
                            o_data  <= special_data;
                        end else begin
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    rem_q <= rem_next;
                    dvd_q <= quo_next;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= StDone;
                        o_valid <= 1'b1;
                        o_data  <= result;
                    end
                end
                StDone: begin
                    if (i_ready) begin
                        state_q <= StIdle;
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
